// File: rtl/counter_1_pkg.sv
// Shared widths and types for the counter_1 multiply-add pipeline.
package counter_1_pkg;

  localparam int unsigned A_W    = 7;
  localparam int unsigned B_W    = 7;
  localparam int unsigned C_W    = 14;
  localparam int unsigned PROD_W = 14;
  localparam int unsigned OUT_W  = 15;

  typedef logic [A_W-1:0]    a_t;
  typedef logic [B_W-1:0]    b_t;
  typedef logic [C_W-1:0]    c_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [OUT_W-1:0]  count_t;

endpackage

// File: rtl/counter_1_stage.sv
// Generic falling-edge pipeline register with asynchronous active-low clear.
module counter_1_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk_n,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: non-blocking assignment so every stage samples its neighbour's pre-edge value.
  always_ff @(negedge clk_n or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/counter_1.sv
// Two-stage registered multiply-add: count = A*B + C, updated on the falling edge of clk_n.
module counter_1
  import counter_1_pkg::*;
(
  input  logic             clk_n,
  input  logic             reset_n,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  input  logic [C_W-1:0]   C,
  output logic [OUT_W-1:0] count
);

  prod_t  prod_d;
  prod_t  prod_q;
  c_t     c_q;
  count_t sum_d;

  // Operands widened before the multiply so the full unsigned 14-bit product is kept.
  assign prod_d = prod_t'(A) * prod_t'(B);
  assign sum_d  = count_t'(prod_q) + count_t'(c_q);

  counter_1_stage #(.W(PROD_W)) u_prod_stage (
    .clk_n   (clk_n),
    .reset_n (reset_n),
    .d       (prod_d),
    .q       (prod_q)
  );

  counter_1_stage #(.W(C_W)) u_c_stage (
    .clk_n   (clk_n),
    .reset_n (reset_n),
    .d       (C),
    .q       (c_q)
  );

  counter_1_stage #(.W(OUT_W)) u_sum_stage (
    .clk_n   (clk_n),
    .reset_n (reset_n),
    .d       (sum_d),
    .q       (count)
  );

endmodule

// File: tb/tb_counter_1.sv
// Directed bench for counter_1: scoreboard queue of expected results, two-edge latency.
module tb_counter_1;
  import counter_1_pkg::*;

  logic   clk_n;
  logic   reset_n;
  a_t     a;
  b_t     b;
  c_t     c;
  count_t count;

  int checks   = 0;
  int failures = 0;

  count_t exp_q[$];

  counter_1 dut (
    .clk_n   (clk_n),
    .reset_n (reset_n),
    .A       (a),
    .B       (b),
    .C       (c),
    .count   (count)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input count_t obs, input count_t expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one input set, take one falling edge, retire the result due at this edge.
  task automatic step(input string tag, input int av, input int bv, input int cv);
    a = a_t'(av);
    b = b_t'(bv);
    c = c_t'(cv);
    @(negedge clk_n);
    #1;
    if (exp_q.size() > 0) check(tag, count, exp_q.pop_front());
    else check({tag, "_sb_empty"}, count_t'(exp_q.size()), count_t'(1));
    exp_q.push_back(count_t'(av * bv + cv));
  endtask

  // Same as step, but garbage is on the inputs across the rising edge before the sample.
  task automatic glitch_step(input string tag, input int av, input int bv, input int cv);
    a = '1;
    b = '1;
    c = '1;
    @(posedge clk_n);
    #1;
    step(tag, av, bv, cv);
  endtask

  task automatic release_reset();
    @(posedge clk_n);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    // Stage 1 holds 0 and 0 after reset, so the first edge delivers 0.
    exp_q.push_back('0);
  endtask

  initial begin
    reset_n = 1'b0;
    a = 7'd40;
    b = 7'd20;
    c = 14'd1234;
    #1;
    check("reset_initial", count, '0);
    @(negedge clk_n);
    #1;
    check("reset_edge1", count, '0);
    @(negedge clk_n);
    #1;
    check("reset_edge2", count, '0);

    release_reset();
    step("post_release_edge1", 40, 20, 1234);
    step("basic_2034", 40, 20, 1234);
    step("basic_hold", 1, 1, 0);

    step("pipe_1", 2, 3, 4);
    step("pipe_10", 5, 5, 5);
    step("pipe_30", 127, 127, 16383);
    step("max_32512", 0, 127, 0);
    step("zero_a", 0, 0, 16383);
    step("zero_ab_c_max", 40, 20, 1234);
    step("pre_reset_2034", 40, 20, 1234);

    // Mid-stream asynchronous reset, pulsed between edges.
    @(posedge clk_n);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_drop", count, '0);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    step("post_reset_no_stale", 3, 7, 100);
    step("post_reset_first", 9, 9, 9);
    step("post_reset_second", 0, 0, 0);

    glitch_step("glitch_a", 10, 11, 12);
    glitch_step("glitch_b", 0, 0, 0);
    glitch_step("glitch_c", 0, 0, 0);
    step("glitch_d", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
